// File: rtl/bitwise_unit_pipe.sv
// Registered bitwise logic unit: eight two-operand bitwise ops with zr/ng flags,
// valid/ready streaming in and out, results buffered in an in-order output FIFO.
module bitwise_unit_pipe #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zr,
  output logic                       out_ng,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [COUNT_W-1:0]         done_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready and out_valid come from registered occupancy only, so neither
  // side's ready/valid ever depends combinationally on the other side.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic [WIDTH-1:0]   r_mem_data [DEPTH];
  logic               r_mem_zr   [DEPTH];
  logic               r_mem_ng   [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [COUNT_W-1:0] r_done_count;

  logic [WIDTH-1:0]   w_result;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;

  always_comb begin
    w_result = '0;
    case (in_op)
      OP_NOT:  w_result = ~in_a;
      OP_AND:  w_result = in_a & in_b;
      OP_OR:   w_result = in_a | in_b;
      OP_XOR:  w_result = in_a ^ in_b;
      OP_NAND: w_result = ~(in_a & in_b);
      OP_NOR:  w_result = ~(in_a | in_b);
      OP_XNOR: w_result = ~(in_a ^ in_b);
      OP_PASS: w_result = in_a;
      default: w_result = '0;
    endcase
  end

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  // Storage is not reset; pointers and occupancy decide what is visible.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem_data[r_wr_ptr] <= w_result;
      r_mem_zr[r_wr_ptr]   <= ~|w_result;
      r_mem_ng[r_wr_ptr]   <= w_result[WIDTH-1];
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_done_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
        r_done_count <= r_done_count + COUNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign in_ready   = !w_full;
  assign out_valid  = !w_empty;
  assign out_data   = w_empty ? '0   : r_mem_data[r_rd_ptr];
  assign out_zr     = w_empty ? 1'b0 : r_mem_zr[r_rd_ptr];
  assign out_ng     = w_empty ? 1'b0 : r_mem_ng[r_rd_ptr];
  assign level      = r_level;
  assign done_count = r_done_count;

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Bench for bitwise_unit_pipe: a 16-bit instance and an 8-bit/COUNT_W=2 instance,
// each tracked by a truth-table/queue model compared every cycle, plus literal checks.
module tb_bitwise_unit_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- 16-bit instance ----------------
  logic        v16, r16_in, ordy16, ov16, zr16, ng16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, d16, dc16;
  logic [1:0]  lvl16;

  bitwise_unit_pipe u16 (
    .clk(clk), .reset(reset),
    .in_valid(v16), .in_ready(r16_in), .in_op(op16), .in_a(a16), .in_b(b16),
    .out_valid(ov16), .out_ready(ordy16), .out_data(d16), .out_zr(zr16), .out_ng(ng16),
    .level(lvl16), .done_count(dc16)
  );

  // ---------------- 8-bit instance ----------------
  logic       v8, r8_in, ordy8, ov8, zr8, ng8;
  logic [2:0] op8;
  logic [7:0] a8, b8, d8;
  logic [1:0] lvl8, dc8;

  bitwise_unit_pipe #(.WIDTH(8), .DEPTH(2), .COUNT_W(2)) u8 (
    .clk(clk), .reset(reset),
    .in_valid(v8), .in_ready(r8_in), .in_op(op8), .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(d8), .out_zr(zr8), .out_ng(ng8),
    .level(lvl8), .done_count(dc8)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [15:0] model_op(input int w, input logic [2:0] op,
                                           input logic [15:0] a, input logic [15:0] b);
    logic [3:0] tt [8];
    logic [3:0] t;
    logic [15:0] r;
    tt[0] = 4'b0011; tt[1] = 4'b1000; tt[2] = 4'b1110; tt[3] = 4'b0110;
    tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b1001; tt[7] = 4'b1100;
    t = tt[op];
    r = '0;
    for (int i = 0; i < w; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  logic [15:0] exp_q16[$];
  logic [7:0]  exp_q8[$];
  int          cnt16 = 0;
  int          cnt8  = 0;

  always @(posedge clk) begin
    bit push, pop;
    logic [15:0] tmp;
    if (reset) begin
      exp_q16.delete(); exp_q8.delete(); cnt16 = 0; cnt8 = 0;
    end else begin
      pop  = ordy16 && exp_q16.size() > 0;
      push = v16 && exp_q16.size() < 2;
      if (pop) begin void'(exp_q16.pop_front()); cnt16++; end
      if (push) exp_q16.push_back(model_op(16, op16, a16, b16));
      pop  = ordy8 && exp_q8.size() > 0;
      push = v8 && exp_q8.size() < 2;
      if (pop) begin void'(exp_q8.pop_front()); cnt8++; end
      if (push) begin
        tmp = model_op(8, op8, {8'h00, a8}, {8'h00, b8});
        exp_q8.push_back(tmp[7:0]);
      end
    end
  end

  // Outputs depend only on registered state, so sampling at negedge is race-free.
  always @(negedge clk) begin
    logic [15:0] e16;
    logic [7:0]  e8;
    if (started) begin
      e16 = (exp_q16.size() > 0) ? exp_q16[0] : 16'h0;
      chk("m16_level", 32'(lvl16), 32'(exp_q16.size()));
      chk("m16_out_valid", 32'(ov16), 32'(exp_q16.size() > 0));
      chk("m16_in_ready", 32'(r16_in), 32'(exp_q16.size() < 2));
      chk("m16_data", 32'(d16), 32'(e16));
      chk("m16_zr", 32'(zr16), 32'((exp_q16.size() > 0) && (e16 == 16'h0)));
      chk("m16_ng", 32'(ng16), 32'(e16[15]));
      chk("m16_done", 32'(dc16), 32'(cnt16 % 65536));
      e8 = (exp_q8.size() > 0) ? exp_q8[0] : 8'h0;
      chk("m8_level", 32'(lvl8), 32'(exp_q8.size()));
      chk("m8_out_valid", 32'(ov8), 32'(exp_q8.size() > 0));
      chk("m8_in_ready", 32'(r8_in), 32'(exp_q8.size() < 2));
      chk("m8_data", 32'(d8), 32'(e8));
      chk("m8_zr", 32'(zr8), 32'((exp_q8.size() > 0) && (e8 == 8'h0)));
      chk("m8_ng", 32'(ng8), 32'(e8[7]));
      chk("m8_done", 32'(dc8), 32'(cnt8 % 4));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive16(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    v16 = v; op16 = op; a16 = a; b16 = b;
  endtask

  task automatic drive8(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    v8 = v; op8 = op; a8 = a; b8 = b;
  endtask

  task automatic head16(input string name, input logic [15:0] d, input logic zr, input logic ng);
    chk({name, "_valid"}, 32'(ov16), 32'(1));
    chk({name, "_data"}, 32'(d16), 32'(d));
    chk({name, "_zr"}, 32'(zr16), 32'(zr));
    chk({name, "_ng"}, 32'(ng16), 32'(ng));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    drive16(0, 3'd0, 16'h0, 16'h0); ordy16 = 1'b0;
    drive8(0, 3'd0, 8'h0, 8'h0);    ordy8  = 1'b0;
    step(); step();
    reset = 1'b0;
    started = 1;
    chk("rst_level", 32'(lvl16), 32'(0));
    chk("rst_in_ready", 32'(r16_in), 32'(1));
    chk("rst_out_valid", 32'(ov16), 32'(0));
    chk("rst_done", 32'(dc16), 32'(0));

    // NOT
    ordy16 = 1'b1;
    drive16(1, 3'd0, 16'h0000, 16'h0);
    step(); head16("not0", 16'hFFFF, 0, 1);
    drive16(1, 3'd0, 16'hAAAA, 16'h0);
    step(); head16("notA", 16'h5555, 0, 0);
    drive16(0, 3'd0, 16'h0, 16'h0);
    step();

    // XOR / NAND zero flag
    drive16(1, 3'd3, 16'h1234, 16'h1234);
    step(); head16("xor", 16'h0000, 1, 0);
    drive16(1, 3'd4, 16'hFFFF, 16'hFFFF);
    step(); head16("nand", 16'h0000, 1, 0);
    drive16(0, 3'd0, 16'h0, 16'h0);
    step();

    // Backpressure
    ordy16 = 1'b0;
    drive16(1, 3'd2, 16'h00F0, 16'h0F00); step();
    drive16(1, 3'd1, 16'hFF00, 16'h0FF0); step();
    drive16(1, 3'd7, 16'h8000, 16'h1234); step();
    chk("bp_level_full", 32'(lvl16), 32'(2));
    chk("bp_in_ready", 32'(r16_in), 32'(0));
    step();
    chk("bp_hold_level", 32'(lvl16), 32'(2));
    head16("bp_head0", 16'h0FF0, 0, 0);
    ordy16 = 1'b1;
    step(); head16("bp_head1", 16'h0F00, 0, 0);
    chk("bp_level_after_pop", 32'(lvl16), 32'(1));
    step(); head16("bp_head2", 16'h8000, 0, 1);
    drive16(0, 3'd0, 16'h0, 16'h0);
    step();
    chk("bp_drained", 32'(lvl16), 32'(0));
    chk("bp_done_total", 32'(dc16), 32'(7));

    // Simultaneous push/pop at level 1
    ordy16 = 1'b0;
    drive16(1, 3'd6, 16'hC3C3, 16'h0F0F); step();
    ordy16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive16(1, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      step();
      chk("pp_level", 32'(lvl16), 32'(1));
    end
    drive16(0, 3'd0, 16'h0, 16'h0);
    step();
    chk("pp_done_total", 32'(dc16), 32'(13));

    // Reset while full
    ordy16 = 1'b0;
    drive16(1, 3'd7, 16'hBEEF, 16'h0); step();
    drive16(1, 3'd7, 16'h1111, 16'h0); step();
    chk("rf_full", 32'(lvl16), 32'(2));
    reset = 1'b1;
    drive16(1, 3'd7, 16'h2222, 16'h0); ordy16 = 1'b1;
    step();
    chk("rf_level", 32'(lvl16), 32'(0));
    chk("rf_out_valid", 32'(ov16), 32'(0));
    chk("rf_data", 32'(d16), 32'(0));
    chk("rf_in_ready", 32'(r16_in), 32'(1));
    chk("rf_done", 32'(dc16), 32'(0));
    reset = 1'b0;
    drive16(0, 3'd0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rf_no_stale", 32'(ov16), 32'(0));
    end

    // 8-bit instance
    ordy8 = 1'b1;
    drive8(1, 3'd5, 8'hF0, 8'h0C);
    step();
    chk("w8_nor", 32'(d8), 32'(8'h03));
    drive8(1, 3'd6, 8'hF0, 8'h3C);
    step();
    chk("w8_xnor", 32'(d8), 32'(8'h33));
    drive8(1, 3'd7, 8'h01, 8'h00);
    step();
    chk("w8_done2", 32'(dc8), 32'(2));
    drive8(1, 3'd7, 8'h80, 8'h00);
    step();
    chk("w8_pass80_ng", 32'(ng8), 32'(1));
    drive8(0, 3'd0, 8'h0, 8'h0);
    step();
    chk("w8_done_wrap", 32'(dc8), 32'(0));
    step();

    started = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
